// File: rtl/slt_share_arbiter_pkg.sv
// Shared constants and requester id type for the shared set-less-than arbiter.
package slt_share_arbiter_pkg;

   localparam int unsigned NUM_REQ   = 2;
   localparam int unsigned REQ_ALU   = 0;
   localparam int unsigned REQ_BR    = 1;
   localparam int unsigned DEF_WIDTH = 64;

   typedef enum logic {
      ID_ALU = 1'b0,
      ID_BR  = 1'b1
   } req_id_e;

endpackage

// File: rtl/slt_share_arbiter_set_less_than.sv
// Signed set-less-than comparator; unsigned compares are handled by the caller via MSB flipping.
module set_less_than
   import slt_share_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             less_o
);

   always_comb begin
      less_o = ($signed(a_i) < $signed(b_i));
   end

endmodule

// File: rtl/slt_share_arbiter.sv
// Round-robin share of one set-less-than comparator between the ALU (req 0) and branch unit (req 1),
// with a registered operand stage and per-requester held responses.
module slt_share_arbiter
   import slt_share_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_ready,
   input  logic [WIDTH-1:0]   req_a0,
   input  logic [WIDTH-1:0]   req_b0,
   input  logic [WIDTH-1:0]   req_a1,
   input  logic [WIDTH-1:0]   req_b1,
   input  logic [NUM_REQ-1:0] req_uns,
   output logic [NUM_REQ-1:0] rsp_valid,
   input  logic [NUM_REQ-1:0] rsp_ready,
   output logic [NUM_REQ-1:0] rsp_less,
   output logic [CNT_W-1:0]   conflict_cnt
);

   logic [NUM_REQ-1:0] hs, elig, grant, land;
   logic               contest;

   req_id_e            rr_ptr_q, rr_ptr_d;
   logic               s1_valid_q;
   req_id_e            s1_id_q, sel_id;
   logic [WIDTH-1:0]   s1_a_q, s1_b_q, sel_a, sel_b;
   logic               s1_uns_q, sel_uns;

   logic [NUM_REQ-1:0] outstanding_q, outstanding_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [NUM_REQ-1:0] rsp_less_q, rsp_less_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [WIDTH-1:0]   cmp_a, cmp_b;
   logic               cmp_less;

   // A requester may re-issue in the same cycle its held result is consumed.
   always_comb begin
      hs      = rsp_valid_q & rsp_ready;
      elig    = req_valid & (~outstanding_q | hs);
      contest = &elig;
      grant   = '0;
      if (contest) begin
         if (rr_ptr_q == ID_ALU) grant[REQ_ALU] = 1'b1;
         else                    grant[REQ_BR]  = 1'b1;
      end else begin
         grant = elig;
      end
   end

   always_comb begin
      if (grant[REQ_BR]) begin
         sel_id  = ID_BR;
         sel_a   = req_a1;
         sel_b   = req_b1;
         sel_uns = req_uns[REQ_BR];
      end else begin
         sel_id  = ID_ALU;
         sel_a   = req_a0;
         sel_b   = req_b0;
         sel_uns = req_uns[REQ_ALU];
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (contest) rr_ptr_d = (rr_ptr_q == ID_ALU) ? ID_BR : ID_ALU;
      cnt_d = cnt_q;
      if (contest && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   // Flipping both MSBs maps unsigned order onto signed order.
   always_comb begin
      cmp_a = s1_a_q;
      cmp_b = s1_b_q;
      cmp_a[WIDTH-1] = s1_a_q[WIDTH-1] ^ s1_uns_q;
      cmp_b[WIDTH-1] = s1_b_q[WIDTH-1] ^ s1_uns_q;
   end

   set_less_than #(
      .WIDTH (WIDTH)
   ) u_slt (
      .a_i    (cmp_a),
      .b_i    (cmp_b),
      .less_o (cmp_less)
   );

   always_comb begin
      land          = '0;
      land[REQ_ALU] = s1_valid_q && (s1_id_q == ID_ALU);
      land[REQ_BR]  = s1_valid_q && (s1_id_q == ID_BR);
      rsp_valid_d   = land | (rsp_valid_q & ~hs);
      rsp_less_d    = (land & {NUM_REQ{cmp_less}}) | (~land & rsp_less_q);
      outstanding_d = grant | (outstanding_q & ~hs);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q      <= ID_ALU;
         s1_valid_q    <= 1'b0;
         s1_id_q       <= ID_ALU;
         s1_a_q        <= '0;
         s1_b_q        <= '0;
         s1_uns_q      <= 1'b0;
         outstanding_q <= '0;
         rsp_valid_q   <= '0;
         rsp_less_q    <= '0;
         cnt_q         <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         s1_valid_q    <= |grant;
         if (|grant) begin
            s1_id_q  <= sel_id;
            s1_a_q   <= sel_a;
            s1_b_q   <= sel_b;
            s1_uns_q <= sel_uns;
         end
         outstanding_q <= outstanding_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_less_q    <= rsp_less_d;
         cnt_q         <= cnt_d;
      end
   end

   assign req_ready    = grant & {NUM_REQ{rst_n}};
   assign rsp_valid    = rsp_valid_q;
   assign rsp_less     = rsp_less_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_slt_share_arbiter.sv
// Directed bench for slt_share_arbiter: handshake timing, signed/unsigned compare, contention,
// backpressure, mid-flight reset and counter saturation (second instance with a 4-bit counter).
module tb_slt_share_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  req_valid, req_ready, req_uns, rsp_valid, rsp_ready, rsp_less;
   logic [63:0] req_a0, req_b0, req_a1, req_b1;
   logic [15:0] conflict_cnt;

   logic        s_rst_n;
   logic [1:0]  s_req_valid, s_req_ready, s_req_uns, s_rsp_valid, s_rsp_ready, s_rsp_less;
   logic [63:0] s_a0, s_b0, s_a1, s_b1;
   logic [3:0]  s_cnt;

   int n_total = 0;
   int n_bad   = 0;

   slt_share_arbiter #(.WIDTH(64), .CNT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a0       (req_a0),
      .req_b0       (req_b0),
      .req_a1       (req_a1),
      .req_b1       (req_b1),
      .req_uns      (req_uns),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_less     (rsp_less),
      .conflict_cnt (conflict_cnt)
   );

   slt_share_arbiter #(.WIDTH(64), .CNT_W(4)) dut_sat (
      .clk          (clk),
      .rst_n        (s_rst_n),
      .req_valid    (s_req_valid),
      .req_ready    (s_req_ready),
      .req_a0       (s_a0),
      .req_b0       (s_b0),
      .req_a1       (s_a1),
      .req_b1       (s_b1),
      .req_uns      (s_req_uns),
      .rsp_valid    (s_rsp_valid),
      .rsp_ready    (s_rsp_ready),
      .rsp_less     (s_rsp_less),
      .conflict_cnt (s_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Isolated request: grant in cycle 0, result visible in cycle 2, gone in cycle 3.
   task automatic run_one(input int i, input logic [63:0] a, input logic [63:0] b,
                          input logic u, input logic exp_less, input string tag);
      logic [1:0] m;
      m = '0;
      m[i] = 1'b1;
      @(negedge clk);
      if (i == 0) begin req_a0 = a; req_b0 = b; end
      else        begin req_a1 = a; req_b1 = b; end
      req_uns = '0;
      req_uns[i] = u;
      req_valid = m;
      #1 chk({tag, ".rdy"}, req_ready, m);
      @(negedge clk);
      req_valid = '0;
      #1 chk({tag, ".rv1"}, rsp_valid, 2'b00);
      @(negedge clk);
      #1 chk({tag, ".rv2"}, rsp_valid, m);
      chk({tag, ".less"}, rsp_less[i], exp_less);
      @(negedge clk);
      #1 chk({tag, ".rv3"}, rsp_valid, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] ct_rdy [5];
      logic [1:0] ct_rv  [5];
      logic [15:0] ct_cnt [5];
      ct_rdy = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
      ct_rv  = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
      ct_cnt = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd1};

      rst_n = 1'b0; req_valid = 2'b11; req_uns = '0; rsp_ready = '0;
      req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
      s_rst_n = 1'b0; s_req_valid = '0; s_req_uns = '0; s_rsp_ready = '0;
      s_a0 = '0; s_b0 = '0; s_a1 = '0; s_b1 = '0;

      repeat (2) @(negedge clk);
      #1 chk("rst.rdy", req_ready, 2'b00);
      chk("rst.rv", rsp_valid, 2'b00);
      chk("rst.less", rsp_less, 2'b00);
      chk("rst.cnt", conflict_cnt, 16'd0);
      @(negedge clk);
      rst_n = 1'b1; req_valid = '0; rsp_ready = 2'b11;

      run_one(0, 64'd10, 64'd20, 1'b0, 1'b1, "basic");
      run_one(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, "s_neg1");
      run_one(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, "u_max");
      run_one(1, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, "s_min");
      run_one(0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, "u_min");
      run_one(0, 64'd5, 64'd5, 1'b0, 1'b0, "eq");
      run_one(0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "u_small");

      // contention from a fresh reset
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      req_a0 = 64'd30; req_b0 = 64'd15; req_a1 = 64'd0; req_b1 = 64'd0;
      req_uns = '0; rsp_ready = 2'b11;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         req_valid = 2'b11;
         #1 chk($sformatf("ct.rdy%0d", k), req_ready, ct_rdy[k]);
         chk($sformatf("ct.rv%0d", k), rsp_valid, ct_rv[k]);
         chk($sformatf("ct.cnt%0d", k), conflict_cnt, ct_cnt[k]);
         if (k >= 2) chk($sformatf("ct.less%0d", k), rsp_less, 2'b00);
      end
      @(negedge clk); req_valid = '0;
      repeat (3) @(negedge clk);
      #1 chk("ct.drain", rsp_valid, 2'b00);

      // backpressure on requester 0
      rsp_ready = 2'b10;
      @(negedge clk);
      req_a0 = 64'd1; req_b0 = 64'd2; req_valid = 2'b01;
      #1 chk("bp.rdy0", req_ready, 2'b01);
      @(negedge clk);
      req_a0 = 64'd5; req_b0 = 64'd2; req_a1 = 64'd3; req_b1 = 64'd3; req_valid = 2'b11;
      #1 chk("bp.rdy1", req_ready, 2'b10);
      chk("bp.cnt", conflict_cnt, 16'd1);
      @(negedge clk);
      req_valid = 2'b01;
      #1 chk("bp.rdy2", req_ready, 2'b00);
      chk("bp.rv2", rsp_valid, 2'b01);
      chk("bp.less2", rsp_less[0], 1'b1);
      @(negedge clk);
      #1 chk("bp.rdy3", req_ready, 2'b00);
      chk("bp.rv3", rsp_valid, 2'b11);
      chk("bp.less3", rsp_less, 2'b01);
      for (int k = 4; k <= 6; k++) begin
         @(negedge clk);
         #1 chk($sformatf("bp.rdy%0d", k), req_ready, 2'b00);
         chk($sformatf("bp.rv%0d", k), rsp_valid, 2'b01);
         chk($sformatf("bp.less%0d", k), rsp_less[0], 1'b1);
      end
      @(negedge clk);
      rsp_ready = 2'b11;
      #1 chk("bp.rel_rdy", req_ready, 2'b01);
      chk("bp.rel_rv", rsp_valid, 2'b01);
      @(negedge clk);
      req_valid = '0; req_a0 = 64'd0;
      #1 chk("bp.rv8", rsp_valid, 2'b00);
      @(negedge clk);
      #1 chk("bp.rv9", rsp_valid, 2'b01);
      chk("bp.less9", rsp_less[0], 1'b0);
      @(negedge clk);
      #1 chk("bp.rv10", rsp_valid, 2'b00);

      // reset one cycle after a grant; rr_ptr was left pointing at requester 1
      @(negedge clk);
      req_a0 = 64'd1; req_b0 = 64'd2; req_valid = 2'b01;
      #1 chk("mr.rdy", req_ready, 2'b01);
      chk("mr.cnt_pre", conflict_cnt, 16'd1);
      @(negedge clk);
      rst_n = 1'b0; req_valid = 2'b11;
      #1 chk("mr.rdy_rst", req_ready, 2'b00);
      chk("mr.rv_rst", rsp_valid, 2'b00);
      chk("mr.cnt_rst", conflict_cnt, 16'd0);
      @(negedge clk);
      rst_n = 1'b1; req_valid = '0;
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("mr.stale%0d", k), rsp_valid, 2'b00);
         @(negedge clk);
      end
      req_a0 = 64'd2; req_b0 = 64'd1; req_a1 = 64'd1; req_b1 = 64'd2; req_valid = 2'b11;
      #1 chk("mr.rr", req_ready, 2'b01);
      @(negedge clk);
      req_valid = '0;
      #1 chk("mr.cnt_post", conflict_cnt, 16'd1);
      repeat (4) @(negedge clk);

      // saturation on the 4-bit counter instance
      @(negedge clk);
      s_rst_n = 1'b1; s_req_valid = 2'b11; s_rsp_ready = 2'b00;
      #1 chk("sat.cnt0", s_cnt, 4'd0);
      for (int k = 1; k <= 20; k++) begin
         int w;
         w = 0;
         while (s_rsp_valid != 2'b11 && w < 10) begin
            @(negedge clk);
            #1 w++;
         end
         if (w >= 10) chk($sformatf("sat.wait%0d", k), s_rsp_valid, 2'b11);
         s_rsp_ready = 2'b11;
         @(negedge clk);
         s_rsp_ready = 2'b00;
         #1 chk($sformatf("sat.cnt%0d", k), s_cnt, (k + 1 > 15) ? 4'd15 : 4'(k + 1));
      end
      repeat (5) @(negedge clk);
      #1 chk("sat.hold", s_cnt, 4'd15);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/slt_share_arbiter.md
Name: slt_share_arbiter

Overview:
- Shares one 64-bit set_less_than comparator between two requesters: the ALU for SLT/SLTU and the branch unit for BLT/BGE/BLTU/BGEU.
- Uses valid/ready handshakes with round-robin arbitration and a registered operand stage.
- Holds a per-requester response register until the requester consumes it.
- Sits between decode/issue and the execute-stage writeback/branch-resolve logic.

Parameters:
- WIDTH, 64, operand width; bit WIDTH-1 is the sign bit.
- CNT_W, 16, width of the saturating contention counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; [0]=ALU, [1]=branch.
- req_ready  out  2  per-requester request accepted this cycle.
- req_a0  in  WIDTH  requester 0 operand a.
- req_b0  in  WIDTH  requester 0 operand b.
- req_a1  in  WIDTH  requester 1 operand a.
- req_b1  in  WIDTH  requester 1 operand b.
- req_uns  in  2  per-requester unsigned-compare flag; 1 = SLTU semantics.
- rsp_valid  out  2  per-requester result valid.
- rsp_ready  in  2  per-requester result consumed.
- rsp_less  out  2  per-requester result; 1 when a < b.
- conflict_cnt  out  CNT_W  saturating count of cycles in which an eligible requester lost arbitration.

Behaviour:
- Reset (async, rst_n=0): req_ready=0 while in reset; rsp_valid=0, rsp_less=0, conflict_cnt=0, S1 stage invalid, rr_ptr=0 (requester 0 favoured), outstanding=0.
- Eligibility: eligible[i] = req_valid[i] && (outstanding[i]==0 || (rsp_valid[i] && rsp_ready[i])).
- Each requester has at most one operation in flight.
- Arbitration is combinational. If one requester is eligible, it is granted. If both are eligible, grant rr_ptr, then set rr_ptr to the other requester at the edge.
- rr_ptr changes only on a contested grant.
- req_ready[i] = grant[i]. At most one grant per cycle.
- Cycle N (grant[i]=1): at the edge, S1 captures a, b, uns, id=i, valid=1, and outstanding[i] is set.
- Cycle N+1: the comparator evaluates S1. At the edge, rsp_less[id] and rsp_valid[id]=1 are written. rsp_valid is visible in cycle N+2. Request-to-response latency is 2 edges.
- Throughput: one grant per cycle across both requesters. A single requester with rsp_ready tied to 1 is granted at most every 2 cycles.
- Unsigned compare: invert bit WIDTH-1 of both a and b, then feed the signed comparator.
- Signed compare: a and b pass unmodified.
- Response hold: rsp_valid[i] and rsp_less[i] stay stable until rsp_ready[i]=1. After the handshake edge, rsp_valid[i]=0 and outstanding[i]=0, unless a new S1 result for i lands on the same edge.
- A handshake and a new grant for the same requester in one cycle are legal. The old result is consumed at edge N, and the new result arrives at edge N+1.
- rsp_ready[i] asserted while rsp_valid[i]=0 is ignored.
- conflict_cnt increments when both requesters are eligible, i.e. one is denied. It saturates at all-ones and never wraps.
- Mid-operation reset clears S1, outstanding, rsp and counter immediately. In-flight results are discarded.
- Operands are sampled only at the grant edge. Changing them afterwards has no effect.

Decomposition:
- Shared package holds the requester id constants REQ_ALU=0 and REQ_BR=1, NUM_REQ=2, and the default WIDTH=64.
- Single sub-module: the existing set_less_than comparator (64-bit signed), instantiated once on the S1 operands after MSB conditioning.
- Arbitration, S1 register and response registers stay in slt_share_arbiter.

Test Plan:
- Single signed request: req0 with a=10, b=20, uns=0, rsp_ready=1 -> req_ready[0]=1 in cycle 0; rsp_valid[0]=1 with rsp_less[0]=1 in cycle 2; rsp_valid[0]=0 in cycle 3.
- Signed vs unsigned: req1 with a=64'hFFFF_FFFF_FFFF_FFFF, b=0, uns=0 -> less=1. Repeat with uns=1 -> less=0. Also a=64'h8000_0000_0000_0000, b=1, uns=0 -> less=1.
- Contention: both valid every cycle, rsp_ready=2'b11, starting from reset:
  - grants alternate 0,1,0,1;
  - conflict_cnt increments on every cycle in which both are eligible;
  - results route to the correct rsp port: req0 a=30,b=15 -> 0; req1 a=0,b=0 -> 0.
- Backpressure: req0 a=1, b=2 with rsp_ready[0]=0 for 5 cycles -> rsp_valid[0]=1 and rsp_less[0]=1 held stable; req_ready[0]=0 for a second req0 while pending; req1 still served. Release rsp_ready[0] -> req0 is granted in the same cycle as the handshake.
- Reset mid-flight: pulse rst_n=0 one cycle after a grant -> rsp_valid=0, conflict_cnt=0, rr_ptr=0 immediately; no stale response after release.
- Saturation, with CNT_W=4: 20 contested cycles -> conflict_cnt=15 and it stays at 15.
